// File: rtl/axi_ni_target_write_sequencer.sv
// Target-side NI write sequencer: drives one AXI write (AW, W burst, B) per decoded
// request header and hands the write response to the response packetizer.
module axi_ni_target_write_sequencer #(
    parameter int AXIADDRWD  = 32,
    parameter int AXIWDATAWD = 32,
    parameter int AXIIDWD    = 4
) (
    input  logic                    clock_i,
    input  logic                    reset_n_i,
    // decoded request header
    input  logic                    hdr_valid_i,
    output logic                    hdr_ready_o,
    input  logic [AXIADDRWD-1:0]    hdr_addr_i,
    input  logic [AXIIDWD-1:0]      hdr_id_i,
    input  logic [7:0]              hdr_len_i,
    input  logic [2:0]              hdr_size_i,
    input  logic [1:0]              hdr_burst_i,
    input  logic [1:0]              hdr_lock_i,
    input  logic [3:0]              hdr_cache_i,
    input  logic [2:0]              hdr_prot_i,
    // payload buffer
    input  logic                    pl_valid_i,
    output logic                    pl_ready_o,
    input  logic [AXIWDATAWD-1:0]   pl_data_i,
    input  logic [AXIWDATAWD/8-1:0] pl_strb_i,
    // AXI write address
    output logic                    AWVALID_o,
    input  logic                    AWREADY_i,
    output logic [AXIADDRWD-1:0]    AWADDR_o,
    output logic [AXIIDWD-1:0]      AWID_o,
    output logic [7:0]              AWLEN_o,
    output logic [2:0]              AWSIZE_o,
    output logic [1:0]              AWBURST_o,
    output logic [1:0]              AWLOCK_o,
    output logic [3:0]              AWCACHE_o,
    output logic [2:0]              AWPROT_o,
    // AXI write data
    output logic                    WVALID_o,
    input  logic                    WREADY_i,
    output logic [AXIWDATAWD-1:0]   WDATA_o,
    output logic [AXIWDATAWD/8-1:0] WSTRB_o,
    output logic [AXIIDWD-1:0]      WID_o,
    output logic                    WLAST_o,
    // AXI write response
    input  logic                    BVALID_i,
    output logic                    BREADY_o,
    input  logic [1:0]              BRESP_i,
    input  logic [AXIIDWD-1:0]      BID_i,
    // response packetizer handoff
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [1:0]              rsp_resp_o,
    output logic [AXIIDWD-1:0]      rsp_id_o
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, SEND} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [AXIADDRWD-1:0]   addr_q;
    logic [AXIIDWD-1:0]     id_q;
    logic [7:0]             len_q;
    logic [2:0]             size_q;
    logic [1:0]             burst_q;
    logic [1:0]             lock_q;
    logic [3:0]             cache_q;
    logic [2:0]             prot_q;
    logic [1:0]             rsp_resp_q;
    logic [AXIIDWD-1:0]     rsp_id_q;
    logic                   last_beat;

    assign last_beat = (cnt_q == len_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hdr_ready_o = 1'b0;
        AWVALID_o   = 1'b0;
        WVALID_o    = 1'b0;
        pl_ready_o  = 1'b0;
        BREADY_o    = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                hdr_ready_o = 1'b1;
                if (hdr_valid_i) begin
                    cnt_d   = 8'd0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                AWVALID_o = 1'b1;
                if (AWREADY_i) state_d = DATA;
            end
            DATA: begin
                WVALID_o   = pl_valid_i;
                pl_ready_o = WREADY_i;
                // The counter stops on the final beat so LEN=255 never wraps to 0.
                if (pl_valid_i && WREADY_i) begin
                    if (last_beat) state_d = RESP;
                    else           cnt_d   = cnt_q + 8'd1;
                end
            end
            RESP: begin
                BREADY_o = 1'b1;
                if (BVALID_i) state_d = SEND;
            end
            SEND: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            id_q       <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            lock_q     <= '0;
            cache_q    <= '0;
            prot_q     <= '0;
            rsp_resp_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && hdr_valid_i) begin
                addr_q  <= hdr_addr_i;
                id_q    <= hdr_id_i;
                len_q   <= hdr_len_i;
                size_q  <= hdr_size_i;
                burst_q <= hdr_burst_i;
                lock_q  <= hdr_lock_i;
                cache_q <= hdr_cache_i;
                prot_q  <= hdr_prot_i;
            end
            // A response carrying a foreign ID is reported as SLVERR under our own ID.
            if (state_q == RESP && BVALID_i) begin
                rsp_id_q   <= id_q;
                rsp_resp_q <= (BID_i == id_q) ? BRESP_i : 2'b10;
            end
        end
    end

    assign AWADDR_o   = addr_q;
    assign AWID_o     = id_q;
    assign AWLEN_o    = len_q;
    assign AWSIZE_o   = size_q;
    assign AWBURST_o  = burst_q;
    assign AWLOCK_o   = lock_q;
    assign AWCACHE_o  = cache_q;
    assign AWPROT_o   = prot_q;
    assign WID_o      = id_q;
    assign WDATA_o    = pl_data_i;
    assign WSTRB_o    = pl_strb_i;
    assign WLAST_o    = (state_q == DATA) && last_beat;
    assign rsp_resp_o = rsp_resp_q;
    assign rsp_id_o   = rsp_id_q;

endmodule

// File: tb/tb_axi_ni_target_write_sequencer.sv
// Directed bench for the target write sequencer: table of whole transactions plus
// hand-written reset and idle-input sequences.
module tb_axi_ni_target_write_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        hdr_valid = 1'b0, hdr_ready;
    logic [31:0] hdr_addr = '0;
    logic [3:0]  hdr_id = '0;
    logic [7:0]  hdr_len = '0;
    logic [2:0]  hdr_size = '0;
    logic [1:0]  hdr_burst = '0;
    logic [1:0]  hdr_lock = '0;
    logic [3:0]  hdr_cache = '0;
    logic [2:0]  hdr_prot = '0;
    logic        pl_valid = 1'b0, pl_ready;
    logic [31:0] pl_data = '0;
    logic [3:0]  pl_strb = '0;
    logic        AWVALID, AWREADY = 1'b0;
    logic [31:0] AWADDR;
    logic [3:0]  AWID;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [1:0]  AWLOCK;
    logic [3:0]  AWCACHE;
    logic [2:0]  AWPROT;
    logic        WVALID, WREADY = 1'b0;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic [3:0]  WID;
    logic        WLAST;
    logic        BVALID = 1'b0, BREADY;
    logic [1:0]  BRESP = '0;
    logic [3:0]  BID = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [1:0]  rsp_resp;
    logic [3:0]  rsp_id;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    axi_ni_target_write_sequencer #(.AXIADDRWD(32), .AXIWDATAWD(32), .AXIIDWD(4)) dut (
        .clock_i(clock), .reset_n_i(reset_n),
        .hdr_valid_i(hdr_valid), .hdr_ready_o(hdr_ready), .hdr_addr_i(hdr_addr), .hdr_id_i(hdr_id),
        .hdr_len_i(hdr_len), .hdr_size_i(hdr_size), .hdr_burst_i(hdr_burst), .hdr_lock_i(hdr_lock),
        .hdr_cache_i(hdr_cache), .hdr_prot_i(hdr_prot),
        .pl_valid_i(pl_valid), .pl_ready_o(pl_ready), .pl_data_i(pl_data), .pl_strb_i(pl_strb),
        .AWVALID_o(AWVALID), .AWREADY_i(AWREADY), .AWADDR_o(AWADDR), .AWID_o(AWID), .AWLEN_o(AWLEN),
        .AWSIZE_o(AWSIZE), .AWBURST_o(AWBURST), .AWLOCK_o(AWLOCK), .AWCACHE_o(AWCACHE), .AWPROT_o(AWPROT),
        .WVALID_o(WVALID), .WREADY_i(WREADY), .WDATA_o(WDATA), .WSTRB_o(WSTRB), .WID_o(WID), .WLAST_o(WLAST),
        .BVALID_i(BVALID), .BREADY_o(BREADY), .BRESP_i(BRESP), .BID_i(BID),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_resp_o(rsp_resp), .rsp_id_o(rsp_id)
    );

    typedef struct {
        logic [7:0]  len;
        logic [31:0] addr;
        logic [3:0]  id;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic        stall;
        int          aw_dly;
        int          b_dly;
        int          rsp_dly;
        logic [3:0]  bid;
        logic [1:0]  bresp;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int t);
        int  beat = 0;
        bit  done = 0;
        logic pv, wr;
        logic [31:0] d;
        logic [3:0]  s;
        // IDLE: present header
        @(negedge clock);
        hdr_valid = 1'b1; hdr_addr = v.addr; hdr_id = v.id; hdr_len = v.len; hdr_size = v.size;
        hdr_burst = v.burst; hdr_lock = v.lock; hdr_cache = v.cache; hdr_prot = v.prot;
        #1 chk($sformatf("t%0d_idle", t), 64'({hdr_ready, AWVALID, rsp_valid}), 64'(3'b100));
        // ADDR: payload already offered, BVALID noise, must not leak onto W
        for (int k = 0; k <= v.aw_dly; k++) begin
            @(negedge clock);
            hdr_valid = 1'b0; hdr_addr = ~v.addr; hdr_len = ~v.len;
            AWREADY = (k == v.aw_dly); pl_valid = 1'b1; WREADY = 1'b1;
            BVALID = 1'b1; BID = ~v.id; BRESP = 2'b11;
            #1;
            chk($sformatf("t%0d_aw_ctl", t), 64'({AWVALID, WVALID, pl_ready, hdr_ready, BREADY}), 64'(5'b10000));
            chk($sformatf("t%0d_aw_fields", t),
                64'({AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, WID}),
                64'({v.addr, v.id, v.len, v.size, v.burst, v.lock, v.cache, v.prot, v.id}));
        end
        // DATA
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clock);
            AWREADY = 1'b0;
            pv = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wr = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            d  = {8'hD0, 8'(t), 16'(beat)};
            s  = 4'(beat) ^ 4'hA;
            pl_valid = pv; WREADY = wr; pl_data = d; pl_strb = s;
            #1 chk($sformatf("t%0d_w_beat%0d", t, beat),
                   64'({WVALID, pl_ready, WLAST, hdr_ready, AWVALID, WDATA, WSTRB}),
                   64'({pv, wr, (beat == int'(v.len)), 1'b0, 1'b0, d, s}));
            if (pv && wr) begin
                if (beat == int'(v.len)) done = 1;
                beat++;
            end
        end
        if (!done) chk($sformatf("t%0d_data_timeout", t), 64'(beat), 64'(v.len) + 1);
        // RESP
        for (int k = 0; k <= v.b_dly; k++) begin
            @(negedge clock);
            pl_valid = 1'b1; WREADY = 1'b1;
            BVALID = (k == v.b_dly); BID = v.bid; BRESP = v.bresp;
            #1 chk($sformatf("t%0d_resp", t), 64'({BREADY, WVALID, pl_ready, rsp_valid}), 64'(4'b1000));
        end
        // SEND
        for (int k = 0; k <= v.rsp_dly; k++) begin
            @(negedge clock);
            pl_valid = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
            rsp_ready = (k == v.rsp_dly);
            #1 chk($sformatf("t%0d_send", t), 64'({rsp_valid, rsp_id, rsp_resp, hdr_ready, BREADY}),
                   64'({1'b1, v.id, v.exp_resp, 1'b0, 1'b0}));
        end
        @(negedge clock);
        rsp_ready = 1'b0;
        #1 chk($sformatf("t%0d_back_idle", t), 64'({hdr_ready, rsp_valid, AWVALID}), 64'(3'b100));
    endtask

    initial begin
        //        len    addr          id    size  burst lock  cache prot  stl aw b  rsp bid   bresp exp
        tv[0] = '{8'd0,   32'h0000_1000, 4'd5, 3'd2, 2'd1, 2'd0, 4'h3, 3'd0, 0, 0, 0, 0, 4'd5, 2'd0, 2'd0};
        tv[1] = '{8'd3,   32'h0000_2000, 4'd3, 3'd1, 2'd1, 2'd1, 4'h2, 3'd2, 1, 0, 0, 0, 4'd3, 2'd1, 2'd1};
        tv[2] = '{8'd255, 32'hDEAD_0000, 4'd15,3'd2, 2'd1, 2'd0, 4'hF, 3'd7, 0, 0, 0, 0, 4'd15,2'd3, 2'd3};
        tv[3] = '{8'd1,   32'h0000_4000, 4'd9, 3'd0, 2'd2, 2'd2, 4'h1, 3'd1, 0, 10,3, 0, 4'd9, 2'd0, 2'd0};
        tv[4] = '{8'd0,   32'h0000_1000, 4'd5, 3'd2, 2'd0, 2'd0, 4'h0, 3'd0, 0, 0, 0, 5, 4'd6, 2'd0, 2'd2};
        tv[5] = '{8'd7,   32'h8000_0040, 4'd0, 3'd3, 2'd1, 2'd3, 4'h6, 3'd4, 1, 2, 1, 1, 4'd0, 2'd2, 2'd2};

        // reset state
        repeat (2) @(negedge clock);
        #1 chk("reset_ctl", 64'({hdr_ready, AWVALID, WVALID, WLAST, BREADY, rsp_valid, pl_ready}), 64'(7'b1000000));
        chk("reset_regs", 64'({AWADDR, AWLEN, WID, rsp_id, rsp_resp}), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;

        // stray handshakes while IDLE are ignored
        @(negedge clock);
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; pl_valid = 1'b1;
        @(negedge clock);
        #1 chk("idle_ignore", 64'({hdr_ready, AWVALID, WVALID, pl_ready, BREADY, rsp_valid}), 64'(6'b100000));
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; pl_valid = 1'b0;

        for (int i = 0; i < 6; i++) run_txn(tv[i], i);

        // reset in the middle of a LEN=3 burst
        @(negedge clock);
        hdr_valid = 1'b1; hdr_addr = 32'h0000_7700; hdr_id = 4'd7; hdr_len = 8'd3;
        @(negedge clock);
        hdr_valid = 1'b0; AWREADY = 1'b1;
        #1 chk("rst_seq_aw", 64'({AWVALID, AWADDR}), 64'({1'b1, 32'h0000_7700}));
        @(negedge clock);
        AWREADY = 1'b0; pl_valid = 1'b1; WREADY = 1'b1;
        #1 chk("rst_seq_w0", 64'({WVALID, WLAST}), 64'(2'b10));
        @(negedge clock);
        reset_n = 1'b0;
        #1 chk("rst_mid_ctl", 64'({hdr_ready, AWVALID, WVALID, WLAST, BREADY, rsp_valid, pl_ready}), 64'(7'b1000000));
        @(negedge clock);
        #1 chk("rst_mid_regs", 64'({AWADDR, AWLEN, WID, WVALID, hdr_ready}), 64'({32'h0, 8'h0, 4'h0, 1'b0, 1'b1}));
        reset_n = 1'b1; pl_valid = 1'b0; WREADY = 1'b0; AWREADY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            #1 chk($sformatf("post_rst_idle%0d", k), 64'({AWVALID, hdr_ready, WVALID}), 64'(3'b010));
        end
        AWREADY = 1'b0;

        // normal operation after reset
        run_txn(tv[0], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
